// File: rtl/ebr_byte_reader.sv
// ebr_byte_reader: word buffer streamed out as a little-endian byte frame with ready/valid handshake
module ebr_byte_reader #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = $clog2(DEPTH * 4) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_q;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [1:0]            byte_q, byte_d;
    logic [31:0]           sh_q, sh_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  hs;

    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign hs        = valid_q && out_ready;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = sh_q[7:0];

    // Buffer: write-anytime port plus a registered read port (read-before-write on collision)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    // Next-state: addr_q always points at the word to prefetch next, rd_q holds the prefetched word
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            IDLE: if (start && start_len != '0) begin
                state_d = FETCH;
                rd_en   = 1'b1;
                rd_addr = start_addr;
                addr_d  = inc(start_addr);
                rem_d   = start_len;
                busy_d  = 1'b1;
            end
            FETCH: begin
                state_d = SEND;
                sh_d    = rd_q;
                byte_d  = 2'd0;
                valid_d = 1'b1;
                last_d  = rem_q == LEN_WIDTH'(1);
                rd_en   = 1'b1;
                addr_d  = inc(addr_q);
            end
            SEND: if (hs) begin
                rem_d  = rem_q - LEN_WIDTH'(1);
                last_d = rem_q == LEN_WIDTH'(2);
                if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (byte_q == 2'd3) begin
                    sh_d   = rd_q;
                    byte_d = 2'd0;
                    rd_en  = 1'b1;
                    addr_d = inc(addr_q);
                end else begin
                    sh_d   = {8'h00, sh_q[31:8]};
                    byte_d = byte_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame but leaves the buffer intact
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end
endmodule
